// File: rtl/ahb_manager_ui_arbiter_pkg.sv
// Shared types for the ahb_manager user-interface arbiter.
//   t_hsize     : AHB transfer size as carried on the manager command interface
//   t_arb_state : arbiter FSM state (idle / driving a granted burst)
//   t_rsp_tag   : read tag queued per outstanding read burst {owner, beat count}
// The tag fields are sized for the largest supported configuration
// (16 requesters, 32-bit beat counts); narrower values are zero-extended.
package ahb_manager_ui_arbiter_pkg;

  localparam int HSIZE_WDT   = 3;
  localparam int OWNER_WDT   = 4;
  localparam int TAG_LEN_WDT = 32;

  typedef logic [HSIZE_WDT-1:0] t_hsize;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } t_arb_state;

  typedef struct packed {
    logic [OWNER_WDT-1:0]   owner;
    logic [TAG_LEN_WDT-1:0] remaining;
  } t_rsp_tag;

endpackage

// File: rtl/ahb_manager_ui_arbiter_tag_fifo.sv
// ahb_manager_tag_fifo: small synchronous FIFO of read tags.
//   clk, rst_n : clock, asynchronous active-low reset (resets to empty)
//   push, din  : enqueue a tag (ignored when full unless a pop happens too)
//   pop        : dequeue the head (ignored when empty)
//   dout       : current head, valid while empty=0
//   full, empty: occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module ahb_manager_tag_fifo
  import ahb_manager_ui_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  t_rsp_tag din,
  input  logic     pop,
  output t_rsp_tag dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  t_rsp_tag       mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ahb_manager_ui_arbiter.sv
// ahb_manager_ui_arbiter: shares one ahb_manager_top command interface
// between NREQ requesters. One whole burst is granted at a time and its beats
// are driven through the command interface, honouring i_ui_stall. Read data,
// which returns in order, is steered back to its owner through a tag FIFO.
//
// Ports
//   i_hclk, i_hreset_n          clock, asynchronous active-low reset
//   i_req/_addr/_size/_wr/_len  per-requester burst request (held until ack)
//   o_req_ack                   one-hot grant pulse
//   i_req_wdata, i_req_wdav     per-requester current write beat
//   o_req_wnext                 one-hot pulse: write beat consumed
//   o_rsp_data/_addr/_dav       registered read response, dav one-hot by owner
//   o_ui_*                      manager command interface
//   i_ui_stall/_data/_addr/_dav manager stall and read data
//   o_dbg_state                 arbiter FSM state for observation
//
// Handshakes: a request is a level on i_req[n] with its fields stable until
// the single-cycle o_req_ack[n]. A write beat is offered by i_req_wdav[n]
// and taken in the cycle o_req_wnext[n] is high (stall low and wdav high).
//
// Build option: define AHB_UI_ARB_STRICT_PRIO_EN for strict priority
// (lowest eligible index wins); default is round-robin.
module ahb_manager_ui_arbiter
  import ahb_manager_ui_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATA_WDT  = 32,
  parameter int BEAT_WDT  = 32,
  parameter int RSP_DEPTH = 4
) (
  input  logic                      i_hclk,
  input  logic                      i_hreset_n,
  input  logic [NREQ-1:0]           i_req,
  input  logic [NREQ*32-1:0]        i_req_addr,
  input  logic [NREQ*HSIZE_WDT-1:0] i_req_size,
  input  logic [NREQ-1:0]           i_req_wr,
  input  logic [NREQ*BEAT_WDT-1:0]  i_req_len,
  output logic [NREQ-1:0]           o_req_ack,
  input  logic [NREQ*DATA_WDT-1:0]  i_req_wdata,
  input  logic [NREQ-1:0]           i_req_wdav,
  output logic [NREQ-1:0]           o_req_wnext,
  output logic [DATA_WDT-1:0]       o_rsp_data,
  output logic [31:0]               o_rsp_addr,
  output logic [NREQ-1:0]           o_rsp_dav,
  output logic                      o_ui_idle,
  output logic                      o_ui_first_xfer,
  output logic                      o_ui_wr,
  output logic                      o_ui_rd,
  output logic                      o_ui_wr_data_dav,
  output logic [31:0]               o_ui_addr,
  output t_hsize                    o_ui_size,
  output logic [BEAT_WDT-1:0]       o_ui_min_len,
  output logic [DATA_WDT-1:0]       o_ui_wr_data,
  input  logic                      i_ui_stall,
  input  logic [DATA_WDT-1:0]       i_ui_data,
  input  logic [31:0]               i_ui_addr,
  input  logic                      i_ui_dav,
  output t_arb_state                o_dbg_state
);

  localparam int OWN_W = $clog2(NREQ);

  // Per-requester views of the flattened request buses
  logic [31:0]          req_addr_a  [NREQ];
  t_hsize               req_size_a  [NREQ];
  logic [BEAT_WDT-1:0]  req_len_a   [NREQ];
  logic [DATA_WDT-1:0]  req_wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_addr_a[g]  = i_req_addr[g*32 +: 32];
    assign req_size_a[g]  = i_req_size[g*HSIZE_WDT +: HSIZE_WDT];
    assign req_len_a[g]   = i_req_len[g*BEAT_WDT +: BEAT_WDT];
    assign req_wdata_a[g] = i_req_wdata[g*DATA_WDT +: DATA_WDT];
  end

  t_arb_state          state;
  logic [OWN_W-1:0]    owner_q;
  logic [31:0]         addr_q;
  t_hsize              size_q;
  logic                wr_q;
  logic [BEAT_WDT-1:0] len_q;
  logic [BEAT_WDT-1:0] remain_q;
  logic                first_q;

  logic                tag_push;
  logic                tag_pop;
  logic                tag_full;
  logic                tag_empty;
  t_rsp_tag            tag_din;
  t_rsp_tag            tag_head;

  // ---------------------------------------------------------------------------
  // Request selection
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0]  elig;
  logic [OWN_W-1:0] pick;
  logic             found;
  logic             grant;

  // A read cannot be granted without a free tag slot; writes are never held.
  assign elig = i_req & (i_req_wr | {NREQ{!tag_full}});

`ifdef AHB_UI_ARB_STRICT_PRIO_EN
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick  = OWN_W'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [OWN_W-1:0] rr_ptr;

  // Search starts just after the last winner so every requester is reached
  // within NREQ grants.
  always_comb begin
    int j;
    j     = 0;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && elig[j]) begin
        pick  = OWN_W'(j);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n)  rr_ptr <= OWN_W'(NREQ - 1);
    else if (grant)   rr_ptr <= pick;
  end
`endif

  assign grant     = (state == S_IDLE) && found;
  assign o_req_ack = grant ? (NREQ'(1) << pick) : '0;

  // Zero-length bursts are acknowledged but never reach the bus, so they
  // leave no tag behind.
  assign tag_push        = grant && !i_req_wr[pick] && (req_len_a[pick] != '0);
  assign tag_din.owner   = OWNER_WDT'(pick);
  assign tag_din.remaining = TAG_LEN_WDT'(req_len_a[pick]);

  // ---------------------------------------------------------------------------
  // Burst sequencer
  // ---------------------------------------------------------------------------
  logic burst;
  logic beat_ok;
  logic beat_acc;

  assign burst    = (state == S_BURST);
  assign beat_ok  = wr_q ? i_req_wdav[owner_q] : 1'b1;
  assign beat_acc = burst && !i_ui_stall && beat_ok;

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state    <= S_IDLE;
      owner_q  <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      len_q    <= '0;
      remain_q <= '0;
      first_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            owner_q  <= pick;
            addr_q   <= req_addr_a[pick];
            size_q   <= req_size_a[pick];
            wr_q     <= i_req_wr[pick];
            len_q    <= req_len_a[pick];
            remain_q <= req_len_a[pick];
            first_q  <= 1'b1;
            if (req_len_a[pick] != '0) state <= S_BURST;
          end
        end
        S_BURST: begin
          if (beat_acc) begin
            remain_q <= remain_q - BEAT_WDT'(1);
            first_q  <= 1'b0;
            if (remain_q == BEAT_WDT'(1)) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ui_idle        = !burst;
  assign o_ui_first_xfer  = burst && first_q;
  assign o_ui_wr          = burst && wr_q;
  assign o_ui_rd          = burst && !wr_q;
  assign o_ui_addr        = addr_q;
  assign o_ui_size        = size_q;
  assign o_ui_min_len     = len_q;
  assign o_ui_wr_data     = (burst && wr_q) ? req_wdata_a[owner_q] : '0;
  assign o_ui_wr_data_dav = burst && wr_q && i_req_wdav[owner_q];
  assign o_req_wnext      = (beat_acc && wr_q) ? (NREQ'(1) << owner_q) : '0;
  assign o_dbg_state      = state;

  // ---------------------------------------------------------------------------
  // Read response steering
  // ---------------------------------------------------------------------------
  logic                   rsp_take;
  logic [TAG_LEN_WDT-1:0] rsp_beat;

  // Beats delivered for the head tag are counted here instead of rewriting
  // the head entry; the tag leaves when the count reaches its length.
  assign rsp_take = i_ui_dav && !tag_empty;
  assign tag_pop  = rsp_take && (rsp_beat == tag_head.remaining - TAG_LEN_WDT'(1));

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      o_rsp_dav  <= '0;
      o_rsp_data <= '0;
      o_rsp_addr <= '0;
      rsp_beat   <= '0;
    end else begin
      o_rsp_dav <= rsp_take ? (NREQ'(1) << tag_head.owner) : '0;
      if (rsp_take) begin
        o_rsp_data <= i_ui_data;
        o_rsp_addr <= i_ui_addr;
        rsp_beat   <= tag_pop ? '0 : rsp_beat + TAG_LEN_WDT'(1);
      end
    end
  end

  ahb_manager_tag_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_tag_fifo (
    .clk   (i_hclk),
    .rst_n (i_hreset_n),
    .push  (tag_push),
    .din   (tag_din),
    .pop   (tag_pop),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

endmodule

// File: tb/tb_ahb_manager_ui_arbiter.sv
module tb_ahb_manager_ui_arbiter;
  import ahb_manager_ui_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int BW   = 32;
  localparam int RD   = 4;
  localparam logic [31:0] RSP_KEY = 32'h5A5A_0000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NREQ-1:0]    req      = '0;
  logic [NREQ*32-1:0] req_addr = '0;
  logic [NREQ*3-1:0]  req_size = '0;
  logic [NREQ-1:0]    req_wr   = '0;
  logic [NREQ*BW-1:0] req_len  = '0;
  logic [NREQ*DW-1:0] wdata    = '0;
  logic [NREQ-1:0]    wdav     = '1;
  logic               ui_stall = 1'b0;
  logic [DW-1:0]      ui_data  = '0;
  logic [31:0]        ui_addr  = '0;
  logic               ui_dav   = 1'b0;

  logic [NREQ-1:0] req_ack, req_wnext, rsp_dav;
  logic [DW-1:0]   rsp_data, ui_wr_data;
  logic [31:0]     rsp_addr, ui_addr_o;
  logic            ui_idle, ui_first, ui_wr, ui_rd, ui_wr_dav;
  t_hsize          ui_size;
  logic [BW-1:0]   ui_min_len;
  t_arb_state      dbg_state;

  ahb_manager_ui_arbiter #(
    .NREQ(NREQ), .DATA_WDT(DW), .BEAT_WDT(BW), .RSP_DEPTH(RD)
  ) dut (
    .i_hclk(clk), .i_hreset_n(rst_n),
    .i_req(req), .i_req_addr(req_addr), .i_req_size(req_size),
    .i_req_wr(req_wr), .i_req_len(req_len), .o_req_ack(req_ack),
    .i_req_wdata(wdata), .i_req_wdav(wdav), .o_req_wnext(req_wnext),
    .o_rsp_data(rsp_data), .o_rsp_addr(rsp_addr), .o_rsp_dav(rsp_dav),
    .o_ui_idle(ui_idle), .o_ui_first_xfer(ui_first), .o_ui_wr(ui_wr),
    .o_ui_rd(ui_rd), .o_ui_wr_data_dav(ui_wr_dav), .o_ui_addr(ui_addr_o),
    .o_ui_size(ui_size), .o_ui_min_len(ui_min_len), .o_ui_wr_data(ui_wr_data),
    .i_ui_stall(ui_stall), .i_ui_data(ui_data), .i_ui_addr(ui_addr),
    .i_ui_dav(ui_dav), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [3:0]  exp_ack_q[$];   // expected grant order
  logic [35:0] exp_rsp_q[$];   // expected {owner, address} per response beat
  logic [31:0] pend_q[$];      // read beats issued to the modelled manager

  int vectors = 0, miscompares = 0;
  int cyc = 0, ack_cnt = 0, rsp_cnt = 0, fx_cnt = 0, wnext_cnt = 0;
  int busy_cnt = 0, addr_bad = 0, wbeat = 0, rd_idx = 0, ack_rsp_mark = 0;
  int hold_target = 0, rr_last = NREQ - 1;
  bit hold_req = 0, rsp_en = 0, stall_mode = 0, wdav_mode = 0, chk_addr = 0;
  bit inject = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: winner among mask after the last winner.
  function automatic int model_pick(input logic [NREQ-1:0] m, input int last);
`ifdef AHB_UI_ARB_STRICT_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (m[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (m[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int r, input logic [31:0] a, input logic w, input logic [31:0] len);
    req_addr[r*32 +: 32] = a;
    req_size[r*3 +: 3]   = 3'd2;
    req_wr[r]            = w;
    req_len[r*BW +: BW]  = len;
    req[r]               = 1'b1;
  endtask

  // One clock: sample/check at the falling edge, drive just after the rising edge.
  task automatic tick();
    logic [NREQ-1:0] ack_s;
    logic [35:0]     e;
    int              idx;
    @(negedge clk);
    cyc++;
    ack_s = req_ack;
    if (rsp_dav != '0) begin
      rsp_cnt++;
      if (exp_rsp_q.size() == 0) check("rsp_unexpected", rsp_dav, 0);
      else begin
        e = exp_rsp_q.pop_front();
        check("rsp_owner", rsp_dav, 64'(1) << e[35:32]);
        check("rsp_addr", rsp_addr, e[31:0]);
        check("rsp_data", rsp_data, e[31:0] ^ RSP_KEY);
      end
    end
    if (ack_s != '0) begin
      idx = 0;
      for (int i = 0; i < NREQ; i++) if (ack_s[i]) idx = i;
      ack_cnt++;
      ack_rsp_mark = rsp_cnt;
      check("ack_onehot", $onehot(ack_s), 1);
      if (exp_ack_q.size() == 0) check("ack_unexpected", ack_s, 0);
      else check("ack_order", idx, exp_ack_q.pop_front());
    end
    if (ui_first) fx_cnt++;
    if (!ui_idle) busy_cnt++;
    if (chk_addr && !ui_idle && ui_addr_o !== 32'h40) addr_bad++;
    for (int i = 0; i < NREQ; i++) begin
      if (req_wnext[i]) begin
        wnext_cnt++;
        check("wnext_legal", {ui_stall, wdav[i], ui_wr_dav}, 3'b011);
        check("wr_data", ui_wr_data, wdata[i*DW +: DW]);
        wbeat++;
      end
    end
    if (ui_rd && !ui_stall) begin
      if (ui_first) rd_idx = 0;
      pend_q.push_back(ui_addr_o + 32'(4 * rd_idx));
      rd_idx++;
    end
    @(posedge clk);
    #1;
    if (!hold_req) req = req & ~ack_s;
    if (hold_req && ack_cnt >= hold_target) begin
      req = '0;
      hold_req = 0;
    end
    for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = 32'(32'hD000_0000 + i * 65536 + wbeat);
    if (rsp_en && pend_q.size() > 0) begin
      ui_addr = pend_q.pop_front();
      ui_data = ui_addr ^ RSP_KEY;
      ui_dav  = 1'b1;
    end else if (inject) begin
      ui_addr = 32'hDEAD_0000;
      ui_data = 32'h1234_5678;
      ui_dav  = 1'b1;
      inject  = 0;
    end else begin
      ui_dav = 1'b0;
    end
    ui_stall = stall_mode ? cyc[0] : 1'b0;
    wdav     = (!wdav_mode || (cyc % 3) != 0) ? '1 : '0;
  endtask

  // Reset-value snapshot of the outputs: {idle, first, wr, rd, wdav, ack, wnext, rsp_dav}
  function automatic logic [63:0] out_snapshot();
    return 64'({ui_idle, ui_first, ui_wr, ui_rd, ui_wr_dav, req_ack, req_wnext, rsp_dav});
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int n, base, m, w, rb;
    logic [NREQ-1:0] mask;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", out_snapshot(), 64'(1) << (5 + 3 * NREQ - 1));
    check("reset_ui_fields", {ui_addr_o, ui_min_len}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 1) Two 4-beat reads from requesters 0 and 2
    rsp_en = 1;
    base = fx_cnt;
    set_req(0, 32'h100, 1'b0, 4);
    set_req(2, 32'h200, 1'b0, 4);
    exp_ack_q.push_back(0);
    exp_ack_q.push_back(2);
    for (int k = 0; k < 4; k++) exp_rsp_q.push_back({4'd0, 32'(32'h100 + 4 * k)});
    for (int k = 0; k < 4; k++) exp_rsp_q.push_back({4'd2, 32'(32'h200 + 4 * k)});
    rr_last = 2;
    n = 0;
    while (n < 60 && (exp_rsp_q.size() != 0 || exp_ack_q.size() != 0)) begin tick(); n++; end
    check("t1_drain", exp_rsp_q.size() + exp_ack_q.size(), 0);
    check("t1_first_xfer", fx_cnt - base, 2);

    // 2) 3-beat write at 0x40 with stall toggling and gapped write data
    repeat (2) tick();
    stall_mode = 1; wdav_mode = 1; chk_addr = 1;
    base = wnext_cnt;
    set_req(1, 32'h40, 1'b1, 3);
    exp_ack_q.push_back(1);
    rr_last = 1;
    n = 0;
    while (n < 80 && (wnext_cnt - base) < 3) begin tick(); n++; end
    repeat (4) tick();
    check("t2_wnext_count", wnext_cnt - base, 3);
    check("t2_addr_held", addr_bad, 0);
    stall_mode = 0; wdav_mode = 0; chk_addr = 0;
    repeat (2) tick();

    // 3) All requesters hold 1-beat writes: round-robin order
    for (int r = 0; r < NREQ; r++) set_req(r, 32'(32'h300 + 16 * r), 1'b1, 1);
    for (int k = 0; k < 8; k++) begin
      w = model_pick('1, rr_last);
      exp_ack_q.push_back(4'(w));
      rr_last = w;
    end
    hold_target = ack_cnt + 8;
    hold_req = 1;
    n = 0;
    while (n < 60 && exp_ack_q.size() != 0) begin tick(); n++; end
    check("t3_grants", exp_ack_q.size(), 0);
    repeat (3) tick();

    // 4) Five read bursts with responses withheld: fifth waits for a pop
    rsp_en = 0;
    mask = '1;
    for (int r = 0; r < NREQ; r++) set_req(r, 32'(32'h1000 + 32'h100 * r), 1'b0, 2);
    for (int k = 0; k < NREQ; k++) begin
      w = model_pick(mask, rr_last);
      exp_ack_q.push_back(4'(w));
      exp_rsp_q.push_back({4'(w), 32'(32'h1000 + 32'h100 * w)});
      exp_rsp_q.push_back({4'(w), 32'(32'h1004 + 32'h100 * w)});
      mask[w] = 1'b0;
      rr_last = w;
    end
    n = 0;
    while (n < 60 && exp_ack_q.size() != 0) begin tick(); n++; end
    check("t4_four_grants", exp_ack_q.size(), 0);
    repeat (3) tick();
    set_req(0, 32'h500, 1'b0, 1);
    exp_ack_q.push_back(0);
    exp_rsp_q.push_back({4'd0, 32'h500});
    rr_last = 0;
    m = ack_cnt;
    repeat (10) tick();
    check("t4_fifth_blocked", ack_cnt - m, 0);
    rb = rsp_cnt;
    rsp_en = 1;
    n = 0;
    while (n < 30 && ack_cnt == m) begin tick(); n++; end
    check("t4_fifth_acked", ack_cnt - m, 1);
    check("t4_ack_after_pop", ack_rsp_mark - rb, 2);
    n = 0;
    while (n < 60 && exp_rsp_q.size() != 0) begin tick(); n++; end
    check("t4_rsp_drain", exp_rsp_q.size(), 0);
    repeat (3) tick();

    // 5) Zero-length request: ack only, no bus activity, no tag
    base = busy_cnt;
    m = ack_cnt;
    set_req(3, 32'h700, 1'b0, 0);
    exp_ack_q.push_back(3);
    rr_last = 3;
    repeat (6) tick();
    check("t5_ack", ack_cnt - m, 1);
    check("t5_idle", busy_cnt - base, 0);
    rb = rsp_cnt;
    inject = 1;
    repeat (4) tick();
    check("t5_stray_dav", rsp_cnt - rb, 0);
    set_req(1, 32'h600, 1'b0, 1);
    exp_ack_q.push_back(1);
    exp_rsp_q.push_back({4'd1, 32'h600});
    rr_last = 1;
    n = 0;
    while (n < 30 && exp_rsp_q.size() != 0) begin tick(); n++; end
    check("t5_after_read", exp_rsp_q.size(), 0);
    repeat (2) tick();

    // 6) Reset in the middle of an 8-beat write
    set_req(2, 32'h800, 1'b1, 8);
    exp_ack_q.push_back(2);
    base = wnext_cnt;
    n = 0;
    while (n < 40 && (wnext_cnt - base) < 2) begin tick(); n++; end
    check("t6_two_beats", wnext_cnt - base, 2);
    rst_n = 1'b0;
    req = '0;
    #1;
    check("t6_reset_outputs", out_snapshot(), 64'(1) << (5 + 3 * NREQ - 1));
    check("t6_reset_ui_fields", {ui_addr_o, ui_min_len}, 64'd0);
    pend_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    rr_last = NREQ - 1;
    m = ack_cnt;
    base = wnext_cnt;
    repeat (5) tick();
    check("t6_quiet_after_reset", (ack_cnt - m) + (wnext_cnt - base), 0);
    set_req(1, 32'h900, 1'b1, 1);
    set_req(3, 32'hA00, 1'b1, 1);
    mask = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      w = model_pick(mask, rr_last);
      exp_ack_q.push_back(4'(w));
      mask[w] = 1'b0;
      rr_last = w;
    end
    n = 0;
    while (n < 30 && exp_ack_q.size() != 0) begin tick(); n++; end
    repeat (3) tick();

    check("final_ack_q", exp_ack_q.size(), 0);
    check("final_rsp_q", exp_rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb_manager_ui_arbiter.md
Name: ahb_manager_ui_arbiter

Overview:
- Round-robin arbiter and burst sequencer that shares one ahb_manager_top user (command) interface between NREQ requesters.
- Grants one whole burst at a time and drives the beats through the command interface, honouring its stall.
- Steers read responses, which arrive in order, back to the requester that owns them, using a tag FIFO.
- Sits between the DMA/CPU-side clients and ahb_manager_top.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DATA_WDT, 32, data width; matches ahb_manager_top.
- BEAT_WDT, 32, burst length width; matches ahb_manager_top.
- RSP_DEPTH, 4, read tag FIFO depth (power of 2); bounds the number of outstanding read bursts.

Ports:
- i_hclk  in  1  clock
- i_hreset_n  in  1  asynchronous active-low reset
- i_req  in  NREQ  per-requester burst request; held until o_req_ack
- i_req_addr  in  NREQ*32  burst base address
- i_req_size  in  NREQ*t_hsize  transfer size
- i_req_wr  in  NREQ  1 = write burst, 0 = read burst
- i_req_len  in  NREQ*BEAT_WDT  exact beat count
- o_req_ack  out  NREQ  one-hot pulse: request granted
- i_req_wdata  in  NREQ*DATA_WDT  write data, current beat
- i_req_wdav  in  NREQ  write data valid
- o_req_wnext  out  NREQ  one-hot pulse: write beat consumed
- o_rsp_data  out  DATA_WDT  read data, shared
- o_rsp_addr  out  32  read address, shared
- o_rsp_dav  out  NREQ  one-hot read-data valid
- o_ui_idle, o_ui_first_xfer, o_ui_wr, o_ui_rd, o_ui_wr_data_dav  out  1 each  to the manager command interface
- o_ui_addr  out  32  to the manager command interface
- o_ui_size  out  t_hsize  to the manager command interface
- o_ui_min_len  out  BEAT_WDT  to the manager command interface
- o_ui_wr_data  out  DATA_WDT  to the manager command interface
- i_ui_stall  in  1  manager o_stall
- i_ui_data  in  DATA_WDT  manager read data
- i_ui_addr  in  32  manager read address
- i_ui_dav  in  1  manager read-data valid

Behaviour:
- Reset values: state S_IDLE; o_ui_idle=1; all other outputs 0; RR pointer = NREQ-1, so requester 0 wins first; tag FIFO empty.
- Reset mid-burst aborts the burst: no acks, no response pulses after release.
- S_IDLE:
  - o_ui_idle=1.
  - Eligible requesters: i_req=1, excluding read requests while the tag FIFO is full.
  - Winner is the first eligible requester after the RR pointer.
  - On a grant: pulse o_req_ack[w]; latch owner, addr, size, wr, len; RR pointer = w.
  - If the read tag FIFO has room, push {w, len} for a read burst.
  - Next state S_BURST, or stay in S_IDLE if len=0 (ack only, no bus activity, no FIFO push).
- S_BURST:
  - o_ui_idle=0.
  - o_ui_addr, o_ui_size, o_ui_wr, o_ui_min_len = latched values, held for the whole burst.
  - o_ui_first_xfer=1 until the first beat is accepted.
  - Read bursts: o_ui_rd=1 every cycle.
  - Write bursts: o_ui_wr_data and o_ui_wr_data_dav are muxed combinationally from the owner's i_req_wdata and i_req_wdav.
  - A beat is accepted when i_ui_stall=0 and the beat is valid (reads: always valid; writes: wdav=1).
  - Each accepted beat decrements the remaining count and clears the first flag.
  - Each accepted write beat pulses o_req_wnext[owner] in the same cycle.
  - When the last beat is accepted, next state is S_IDLE, with o_ui_idle=1 the following cycle.
  - Minimum gap between bursts is 1 idle cycle.
- Response path, 1-cycle registered latency:
  - On i_ui_dav with the FIFO non-empty, assert o_rsp_dav[head.owner] next cycle, with o_rsp_data/o_rsp_addr registered from i_ui_data/i_ui_addr.
  - Decrement head.remaining; pop the head when it reaches 0.
  - A push and a pop in the same cycle are both honoured.
  - i_ui_dav with the FIFO empty: the data is discarded and no o_rsp_dav is raised.
- Fairness: round-robin guarantees every requester is granted within NREQ grants.

Optional Feature:
- Macro AHB_UI_ARB_STRICT_PRIO_EN.
- Defined: strict priority, lowest index eligible wins, and the RR pointer is not used.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Add to ahb_manager_pack:
  - t_arb_state enum {S_IDLE, S_BURST}.
  - Tag struct t_rsp_tag {owner index, remaining BEAT_WDT}.
- One natural sub-module, ahb_manager_tag_fifo: synchronous FIFO with depth RSP_DEPTH, push/pop/full/empty, asynchronous reset to empty.
- The arbiter's pick logic stays inline.

Test Plan:
- Requesters 0 and 2 each request a 4-beat read at 0x100/0x200, no stall.
  - Required: ack0 then ack2.
  - Required: o_ui_first_xfer high on exactly 1 cycle per burst.
  - Required: 4 o_rsp_dav[0] pulses, then 4 o_rsp_dav[2] pulses.
- Write burst, len=3, with i_ui_stall toggling 1/0 and wdav gapped.
  - Required: exactly 3 wnext pulses, each only when stall=0 and wdav=1.
  - Required: o_ui_addr stays 0x40 throughout.
- All 4 requesters hold i_req continuously with 1-beat bursts.
  - Required: grant order 0,1,2,3,0,…
  - With AHB_UI_ARB_STRICT_PRIO_EN defined: 0 is granted repeatedly.
- 5 read bursts with RSP_DEPTH=4 and responses withheld.
  - Required: the 5th request is not acked until the first response burst completes and pops.
- Request with len=0.
  - Required: ack pulse only; o_ui_idle stays 1 and the FIFO is unchanged.
- Assert reset mid write burst at beat 2 of 8.
  - Required: outputs return to reset values immediately.
  - Required: after release, a new request to requester 1 is granted first.
